// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, flag bit indices, sequencer FSM states and condition selects shared by the ALU sequencer
package alu_pkg;
    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_INC = 2'd2;
    localparam logic [1:0] OP_DEC = 2'd3;
    localparam int FLG_CF = 0;
    localparam int FLG_AF = 1;
    localparam int FLG_ZF = 2;
    localparam int FLG_SF = 3;
    localparam int FLG_OF = 4;
    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;
    localparam logic [2:0] COND_Z  = 3'd0;
    localparam logic [2:0] COND_NZ = 3'd1;
    localparam logic [2:0] COND_C  = 3'd2;
    localparam logic [2:0] COND_NC = 3'd3;
    localparam logic [2:0] COND_S  = 3'd4;
    localparam logic [2:0] COND_NS = 3'd5;
    localparam logic [2:0] COND_O  = 3'd6;
    localparam logic [2:0] COND_T  = 3'd7;
endpackage

// File: rtl/alu_cond_eval.sv
// alu_cond_eval: evaluates a branch-style condition against captured ALU flags, gated by response valid
module alu_cond_eval
    import alu_pkg::*;
(
    input  logic [4:0] flags,
    input  logic       valid,
    input  logic [2:0] cond_sel,
    output logic       cond_true
);
    logic hit;
    // Odd selects are the negated form of the even select just below them.
    always_comb begin
        hit = cond_sel[2:1] == COND_Z[2:1] ? flags[FLG_ZF] :
              cond_sel[2:1] == COND_C[2:1] ? flags[FLG_CF] :
              cond_sel[2:1] == COND_S[2:1] ? flags[FLG_SF] : flags[FLG_OF];
        cond_true = valid && (cond_sel == COND_T || (hit ^ cond_sel[0]));
    end
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issues one-hot ALU strobes per command and captures the result; SEQ_COND_EN adds cond_sel/cond_true
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int ALU_LAT = 1,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [DW-1:0] cmd_x,
    input  logic [DW-1:0] cmd_y,
    output logic          add,
    output logic          sub,
    output logic          inc,
    output logic          dec,
    output logic [DW-1:0] input_x,
    output logic [DW-1:0] input_y,
    input  logic [DW-1:0] alu_b,
    input  logic          CF,
    input  logic          AF,
    input  logic          ZF,
    input  logic          SF,
    input  logic          OF,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic [4:0]    rsp_flags,
    output logic          busy,
`ifdef SEQ_COND_EN
    input  logic [2:0]    cond_sel,
    output logic          cond_true,
`endif
    output logic [7:0]    op_count
);
    state_t state;
    logic [2:0] cnt;
    always_comb begin
        cmd_ready = rst_n && state == ST_IDLE;
        busy = state != ST_IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt <= '0;
            {add, sub, inc, dec} <= '0;
            input_x <= '0;
            input_y <= '0;
            rsp_valid <= 1'b0;
            rsp_data <= '0;
            rsp_flags <= '0;
            op_count <= '0;
        end else begin
            case (state)
                ST_IDLE: if (cmd_valid) begin
                    input_x <= cmd_x;
                    input_y <= cmd_y;
                    add <= cmd_op == OP_ADD;
                    sub <= cmd_op == OP_SUB;
                    inc <= cmd_op == OP_INC;
                    dec <= cmd_op == OP_DEC;
                    state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    {add, sub, inc, dec} <= '0;
                    cnt <= 3'(ALU_LAT);
                    state <= ST_WAIT;
                end
                // The final count edge is the one where alu_b/flags become valid.
                ST_WAIT: if (cnt == 3'd1) begin
                    rsp_data <= alu_b;
                    rsp_flags <= {OF, SF, ZF, AF, CF};
                    rsp_valid <= 1'b1;
                    op_count <= op_count + 8'd1;
                    state <= ST_RESP;
                end else begin
                    cnt <= cnt - 3'd1;
                end
                ST_RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end
`ifdef SEQ_COND_EN
    alu_cond_eval u_cond (
        .flags(rsp_flags),
        .valid(rsp_valid),
        .cond_sel(cond_sel),
        .cond_true(cond_true)
    );
`endif
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: randomized self-checking bench with a behavioural single-cycle ALU and arithmetic reference model
module tb_alu_op_sequencer;
    logic clk = 1'b0, rst_n = 1'b0;
    logic cmd_valid = 1'b0, rsp_ready = 1'b0;
    logic [1:0] cmd_op = '0;
    logic [7:0] cmd_x = '0, cmd_y = '0;
    logic cmd_ready, add, sub, inc, dec, rsp_valid, busy;
    logic [7:0] input_x, input_y, rsp_data, op_count;
    logic [4:0] rsp_flags;
    logic [7:0] alu_b = '0;
    logic [4:0] alu_f = '0;
    logic CF, AF, ZF, SF, OF;
`ifdef SEQ_COND_EN
    logic [2:0] cond_sel = '0;
    logic cond_true;
`endif
    int checks = 0, passes = 0, done = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.ALU_LAT(1), .DW(8)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y),
        .add(add), .sub(sub), .inc(inc), .dec(dec),
        .input_x(input_x), .input_y(input_y), .alu_b(alu_b),
        .CF(CF), .AF(AF), .ZF(ZF), .SF(SF), .OF(OF),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_flags(rsp_flags), .busy(busy),
`ifdef SEQ_COND_EN
        .cond_sel(cond_sel), .cond_true(cond_true),
`endif
        .op_count(op_count)
    );

    // Reference result {OF,SF,ZF,AF,CF,data} from plain integer arithmetic; INC/DEC leave CF clear.
    function automatic logic [12:0] alu_ref(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y);
        int ux, uy, sx, sy, r, sr;
        logic cf, af, of;
        logic [7:0] d;
        ux = x;
        uy = op[1] ? 1 : y;
        sx = $signed(x);
        sy = op[1] ? 1 : $signed(y);
        r = op[0] ? ux - uy : ux + uy;
        sr = op[0] ? sx - sy : sx + sy;
        d = r[7:0];
        cf = op[1] ? 1'b0 : (op[0] ? ux < uy : r > 255);
        af = op[0] ? (ux % 16) < (uy % 16) : (ux % 16) + (uy % 16) > 15;
        of = sr > 127 || sr < -128;
        return {of, d[7], d == 8'd0, af, cf, d};
    endfunction

    // Behavioural ALU with one cycle of latency from the strobe sample edge.
    always @(posedge clk)
        if (add | sub | inc | dec)
            {alu_f, alu_b} <= alu_ref(add ? 2'd0 : sub ? 2'd1 : inc ? 2'd2 : 2'd3, input_x, input_y);
    assign {OF, SF, ZF, AF, CF} = alu_f;

    always @(negedge clk) if (rst_n) begin
        checks++;
        if ($countones({add, sub, inc, dec}) > 1 || (!busy && (add | sub | inc | dec)))
            $display("FAIL strobes at %0t got %b%b%b%b busy=%b want at most one, none when idle", $time, add, sub, inc, dec, busy);
        else passes++;
    end

    task automatic exec(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y,
                        output int lat, output logic [3:0] seen, output int nstr);
        int t = 0;
        cmd_op = op; cmd_x = x; cmd_y = y; cmd_valid = 1'b1;
        while (!cmd_ready && t < 20) begin @(posedge clk); #1; t++; end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 0; seen = '0; nstr = 0;
        while (!rsp_valid && lat < 20) begin
            seen |= {dec, inc, sub, add};
            nstr += $countones({dec, inc, sub, add});
            @(posedge clk); #1;
            lat++;
        end
        seen |= {dec, inc, sub, add};
        nstr += $countones({dec, inc, sub, add});
        done++;
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if ({add, sub, inc, dec, rsp_valid, busy, cmd_ready} !== 7'd0 || input_x !== 8'd0 || input_y !== 8'd0)
            $display("FAIL reset_ctrl got strb=%b%b%b%b rv=%b busy=%b rdy=%b x=%h y=%h want all 0", add, sub, inc, dec, rsp_valid, busy, cmd_ready, input_x, input_y);
        else passes++;
        checks++; if (rsp_data !== 8'd0 || rsp_flags !== 5'd0 || op_count !== 8'd0)
            $display("FAIL reset_data got data=%h flags=%b cnt=%0d want 0", rsp_data, rsp_flags, op_count);
        else passes++;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) $display("FAIL reset_release got rdy=%b busy=%b want 1 0", cmd_ready, busy); else passes++;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        int lat, nstr; logic [3:0] seen;
        exec(2'd0, 8'hF5, 8'hF5, lat, seen, nstr);
        checks++; if (lat !== 2) $display("FAIL add_latency got %0d want 2", lat); else passes++;
        checks++; if (seen !== 4'b0001 || nstr !== 1) $display("FAIL add_strobe got seen=%b cycles=%0d want 0001 1", seen, nstr); else passes++;
        checks++; if (rsp_data !== 8'hEA) $display("FAIL add_data got %h want ea", rsp_data); else passes++;
        checks++; if (rsp_flags !== 5'b01001) $display("FAIL add_flags got %b want 01001", rsp_flags); else passes++;
        checks++; if (op_count !== 8'd1 || cmd_ready !== 1'b0 || busy !== 1'b1)
            $display("FAIL add_resp_state got cnt=%0d rdy=%b busy=%b want 1 0 1", op_count, cmd_ready, busy);
        else passes++;
        consume();
    endtask

    task automatic test_sub();
        int lat, nstr; logic [3:0] seen;
        exec(2'd1, 8'd5, 8'd5, lat, seen, nstr);
        checks++; if (seen !== 4'b0010 || nstr !== 1) $display("FAIL sub_strobe got seen=%b cycles=%0d want 0010 1", seen, nstr); else passes++;
        checks++; if (rsp_data !== 8'h00 || rsp_flags[4:2] !== 3'b001)
            $display("FAIL sub_result got data=%h OSZ=%b want 00 001", rsp_data, rsp_flags[4:2]);
        else passes++;
`ifdef SEQ_COND_EN
        cond_sel = 3'd0; #1;
        checks++; if (cond_true !== 1'b1) $display("FAIL sub_cond_z got %b want 1", cond_true); else passes++;
`endif
        consume();
`ifdef SEQ_COND_EN
        checks++; if (cond_true !== 1'b0) $display("FAIL cond_idle got %b want 0", cond_true); else passes++;
`endif
    endtask

    task automatic test_inc();
        int lat, nstr; logic [3:0] seen;
        exec(2'd2, 8'h7F, 8'h12, lat, seen, nstr);
        checks++; if (seen !== 4'b0100 || nstr !== 1) $display("FAIL inc_strobe got seen=%b cycles=%0d want 0100 1", seen, nstr); else passes++;
        checks++; if (rsp_data !== 8'h80 || rsp_flags[4:2] !== 3'b110)
            $display("FAIL inc_result got data=%h OSZ=%b want 80 110", rsp_data, rsp_flags[4:2]);
        else passes++;
`ifdef SEQ_COND_EN
        cond_sel = 3'd6; #1;
        checks++; if (cond_true !== 1'b1) $display("FAIL inc_cond_o got %b want 1", cond_true); else passes++;
`endif
        consume();
    endtask

    task automatic test_dec_hold();
        int lat, nstr; logic [3:0] seen;
        exec(2'd3, 8'h00, 8'h33, lat, seen, nstr);
        checks++; if (seen !== 4'b1000 || nstr !== 1) $display("FAIL dec_strobe got seen=%b cycles=%0d want 1000 1", seen, nstr); else passes++;
        checks++; if (rsp_data !== 8'hFF || rsp_flags[3:2] !== 2'b10)
            $display("FAIL dec_result got data=%h SZ=%b want ff 10", rsp_data, rsp_flags[3:2]);
        else passes++;
        cmd_op = 2'd0; cmd_x = 8'd1; cmd_y = 8'd1; cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'hFF || cmd_ready !== 1'b0)
                $display("FAIL hold_%0d got rv=%b data=%h rdy=%b want 1 ff 0", i, rsp_valid, rsp_data, cmd_ready);
            else passes++;
        end
        cmd_valid = 1'b0;
        consume();
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1)
            $display("FAIL hold_release got rv=%b busy=%b rdy=%b want 0 0 1", rsp_valid, busy, cmd_ready);
        else passes++;
        repeat (3) @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || op_count !== 8'(done))
            $display("FAIL hold_not_queued got busy=%b cnt=%0d want 0 %0d", busy, op_count, done);
        else passes++;
    endtask

    task automatic test_reset_mid();
        cmd_op = 2'd0; cmd_x = 8'd3; cmd_y = 8'd4; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b1 || rsp_valid !== 1'b0) $display("FAIL mid_in_wait got busy=%b rv=%b want 1 0", busy, rsp_valid); else passes++;
        #1 rst_n = 1'b0;
        #1;
        checks++; if ({add, sub, inc, dec, rsp_valid, busy, cmd_ready} !== 7'd0 || input_x !== 8'd0 || input_y !== 8'd0)
            $display("FAIL mid_reset_ctrl got strb=%b%b%b%b rv=%b busy=%b rdy=%b x=%h y=%h want all 0", add, sub, inc, dec, rsp_valid, busy, cmd_ready, input_x, input_y);
        else passes++;
        checks++; if (rsp_data !== 8'd0 || rsp_flags !== 5'd0 || op_count !== 8'd0)
            $display("FAIL mid_reset_data got data=%h flags=%b cnt=%0d want 0", rsp_data, rsp_flags, op_count);
        else passes++;
        done = 0;
        @(posedge clk); #1 rst_n = 1'b1;
        #1;
        checks++; if (cmd_ready !== 1'b1 || op_count !== 8'd0) $display("FAIL mid_release got rdy=%b cnt=%0d want 1 0", cmd_ready, op_count); else passes++;
        repeat (3) @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) $display("FAIL mid_discard got rv=%b busy=%b want 0 0", rsp_valid, busy); else passes++;
    endtask

    task automatic test_back_to_back();
        logic [12:0] q[$];
        logic [12:0] exp;
        int last = -1, cyc = 0, got = 0;
        logic pend;
        cmd_op = 2'($urandom_range(3)); cmd_x = 8'($urandom); cmd_y = 8'($urandom);
        cmd_valid = 1'b1; rsp_ready = 1'b1;
        while (got < 256 && cyc < 2000) begin
            pend = cmd_valid && cmd_ready;
            if (pend) q.push_back(alu_ref(cmd_op, cmd_x, cmd_y));
            @(posedge clk); #1;
            cyc++;
            if (pend) begin
                if (last >= 0) begin
                    checks++; if (cyc - last !== 4) $display("FAIL b2b_spacing got %0d want 4", cyc - last); else passes++;
                end
                last = cyc;
                cmd_op = 2'($urandom_range(3)); cmd_x = 8'($urandom); cmd_y = 8'($urandom);
            end
            if (rsp_valid) begin
                got++;
                exp = q.size() > 0 ? q.pop_front() : 13'h1FFF;
                checks++; if ({rsp_flags, rsp_data} !== exp)
                    $display("FAIL b2b_rsp_%0d got flags=%b data=%h want flags=%b data=%h", got, rsp_flags, rsp_data, exp[12:8], exp[7:0]);
                else passes++;
                if (got == 255) begin
                    checks++; if (op_count !== 8'd255) $display("FAIL b2b_count_255 got %0d want 255", op_count); else passes++;
                end
            end
        end
        cmd_valid = 1'b0;
        checks++; if (got !== 256 || op_count !== 8'd0) $display("FAIL b2b_wrap got rsps=%0d cnt=%0d want 256 0", got, op_count); else passes++;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        done = 0;
    endtask

    task automatic test_random();
        int lat, nstr, h;
        logic [3:0] seen;
        logic [1:0] op;
        logic [7:0] x, y;
        logic [12:0] exp;
        logic want;
        for (int n = 0; n < 24; n++) begin
            op = 2'($urandom_range(3)); x = 8'($urandom); y = 8'($urandom);
            exp = alu_ref(op, x, y);
            exec(op, x, y, lat, seen, nstr);
            checks++; if (lat !== 2 || nstr !== 1 || seen !== 4'(1 << op))
                $display("FAIL rnd_issue_%0d got lat=%0d cycles=%0d seen=%b want 2 1 op=%0d", n, lat, nstr, seen, op);
            else passes++;
            checks++; if ({rsp_flags, rsp_data} !== exp || op_count !== 8'(done))
                $display("FAIL rnd_rsp_%0d got flags=%b data=%h cnt=%0d want %b %h %0d", n, rsp_flags, rsp_data, op_count, exp[12:8], exp[7:0], done);
            else passes++;
`ifdef SEQ_COND_EN
            for (int s = 0; s < 8; s++) begin
                cond_sel = 3'(s); #1;
                case (s)
                    0: want = exp[10];
                    1: want = !exp[10];
                    2: want = exp[8];
                    3: want = !exp[8];
                    4: want = exp[11];
                    5: want = !exp[11];
                    6: want = exp[12];
                    default: want = 1'b1;
                endcase
                checks++; if (cond_true !== want) $display("FAIL rnd_cond_%0d_sel%0d got %b want %b", n, s, cond_true, want); else passes++;
            end
`endif
            h = $urandom_range(3);
            rsp_ready = 1'b1; #1 rsp_ready = 1'b0;
            repeat (h) begin
                @(posedge clk); #1;
                checks++; if (rsp_valid !== 1'b1 || rsp_data !== exp[7:0])
                    $display("FAIL rnd_hold_%0d got rv=%b data=%h want 1 %h", n, rsp_valid, rsp_data, exp[7:0]);
                else passes++;
            end
            consume();
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_inc();
        test_dec_hold();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1);
    end
endmodule
